// File: rtl/legv8_pkg.sv
// Shared LEGv8 memory-stage types: datapath width, stage FSM states and the
// execute-to-memory bundle, plus the branch-resolution rule.
package legv8_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WB
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] target;
    logic            zero;
    logic [XLEN-1:0] store_data;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            uncond_branch;
    logic            mem_to_reg;
    logic            reg_write;
    logic [4:0]      rd;
  } ex_mem_t;

  // B always redirects; CBZ redirects only when the ALU reported zero.
  function automatic logic branch_taken(input ex_mem_t b);
    return b.uncond_branch | (b.branch & b.zero);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if #(
  parameter int XLEN = legv8_pkg::XLEN
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// Saturating 8-bit count of cycles spent waiting for dmem_ack; tc marks the
// TIMEOUT-th waiting cycle so the stage can abort on that cycle's edge.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign tc = enable && (count >= LAST);

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: captures one execute bundle, resolves the branch and
// runs a data-memory access with timeout before a one-cycle write-back pulse.
module mem_stage #(
  parameter int XLEN        = legv8_pkg::XLEN,
  parameter int TIMEOUT     = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ALU_result,
  input  logic [XLEN-1:0] ADD_result,
  input  logic            Zero,
  input  logic [XLEN-1:0] rd_data_2,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            Branch,
  input  logic            UncondBranch,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  input  logic [4:0]      rd_in,
  mem_stage_if.master     dmem,
  output logic            PCSrc,
  output logic [XLEN-1:0] branch_target,
  output logic            wb_valid,
  output logic            wb_RegWrite,
  output logic            wb_MemtoReg,
  output logic [XLEN-1:0] wb_read_data,
  output logic [XLEN-1:0] wb_ALU_result,
  output logic [4:0]      wb_rd,
  output logic            mem_fault
);
  import legv8_pkg::*;

  state_t  state;
  ex_mem_t ex_in;
  ex_mem_t ex_q;
  logic    accepted_q;
  logic    fault_q;
  logic    mem_op;
  logic    misaligned;
  logic    go_req;
  logic    is_load;
  logic    tc;

  assign ex_in = '{result: ALU_result, target: ADD_result, zero: Zero,
                   store_data: rd_data_2, mem_read: MemRead,
                   mem_write: MemWrite, branch: Branch,
                   uncond_branch: UncondBranch, mem_to_reg: MemtoReg,
                   reg_write: RegWrite, rd: rd_in};

  assign mem_op     = ex_in.mem_read | ex_in.mem_write;
  assign misaligned = CHECK_ALIGN && (ex_in.result[2:0] != 3'b000);
  assign go_req     = ex_valid && mem_op && !misaligned;
  // Read+write together behaves as a store, so only a pure read returns data.
  assign is_load    = ex_q.mem_read & ~ex_q.mem_write;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (go_req && state != REQ),
    .enable(state == REQ),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      // NOTE: the captured bundle is reset too because it drives outputs
      // directly, and every output must read 0 out of reset.
      ex_q          <= '0;
      ex_ready      <= 1'b1;
      accepted_q    <= 1'b0;
      fault_q       <= 1'b0;
      wb_valid      <= 1'b0;
      wb_read_data  <= '0;
      dmem.dmem_req <= 1'b0;
      dmem.dmem_we  <= 1'b0;
    end else begin
      accepted_q <= 1'b0;
      wb_valid   <= 1'b0;
      case (state)
        REQ: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            wb_read_data  <= is_load ? dmem.dmem_rdata : '0;
            fault_q       <= 1'b0;
            wb_valid      <= 1'b1;
            ex_ready      <= 1'b1;
            state         <= WB;
          end else if (tc) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            wb_read_data  <= '0;
            fault_q       <= 1'b1;
            wb_valid      <= 1'b1;
            ex_ready      <= 1'b1;
            state         <= WB;
          end
        end
        default: begin
          // IDLE and WB both accept; WB then chains straight into the next op.
          if (ex_valid) begin
            ex_q         <= ex_in;
            accepted_q   <= 1'b1;
            wb_read_data <= '0;
            if (go_req) begin
              dmem.dmem_req <= 1'b1;
              dmem.dmem_we  <= ex_in.mem_write;
              ex_ready      <= 1'b0;
              state         <= REQ;
            end else begin
              fault_q  <= mem_op & misaligned;
              wb_valid <= 1'b1;
              state    <= WB;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign dmem.dmem_addr  = ex_q.result;
  assign dmem.dmem_wdata = ex_q.store_data;

  assign PCSrc         = accepted_q & branch_taken(ex_q);
  assign branch_target = PCSrc ? ex_q.target : '0;

  assign wb_RegWrite   = wb_valid & ex_q.reg_write & ~fault_q;
  assign wb_MemtoReg   = ex_q.mem_to_reg;
  assign wb_ALU_result = ex_q.result;
  assign wb_rd         = ex_q.rd;
  assign mem_fault     = wb_valid & fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back bundles are queued at
// issue time and matched against each wb_valid pulse.
module tb_mem_stage;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [63:0] alu, add, wd, rdata;
    logic        zero, mr, mw, br, ub, m2r, rw;
    logic [4:0]  rd;
    int          delay;   // REQ cycle carrying the ack; 0 = never ack
  } stim_t;

  typedef struct {
    logic [63:0] alu, rdata;
    logic [4:0]  rd;
    logic        m2r, rw, fault;
    int          acc, lat;
  } exp_t;

  logic            clk, reset, ex_valid, ex_ready;
  logic [XLEN-1:0] ALU_result, ADD_result, rd_data_2;
  logic            Zero, MemRead, MemWrite, Branch, UncondBranch, MemtoReg, RegWrite;
  logic [4:0]      rd_in;
  logic            PCSrc;
  logic [XLEN-1:0] branch_target;
  logic            wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [XLEN-1:0] wb_read_data, wb_ALU_result;
  logic [4:0]      wb_rd;
  logic            mem_fault;

  mem_stage_if #(.XLEN(XLEN)) dmem ();

  mem_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALU_result(ALU_result), .ADD_result(ADD_result), .Zero(Zero),
    .rd_data_2(rd_data_2), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .UncondBranch(UncondBranch), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .rd_in(rd_in), .dmem(dmem), .PCSrc(PCSrc),
    .branch_target(branch_target), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_read_data(wb_read_data), .wb_ALU_result(wb_ALU_result),
    .wb_rd(wb_rd), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  int          rq_cnt = 0;
  int          req_seen = 0;
  bit          force_ack = 1'b0;
  logic [63:0] ack_data = '0;
  logic [63:0] exp_addr = '0;
  logic [63:0] exp_wdata = '0;
  logic        exp_we = 1'b0;
  exp_t        sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: observe outputs and play the memory at the falling edge,
  // then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_read_data", wb_read_data, e.rdata);
        check("wb_ALU_result", wb_ALU_result, e.alu);
        check("wb_rd", 64'(wb_rd), 64'(e.rd));
        check("wb_MemtoReg", 64'(wb_MemtoReg), 64'(e.m2r));
        check("wb_RegWrite", 64'(wb_RegWrite), 64'(e.rw));
        check("mem_fault", 64'(mem_fault), 64'(e.fault));
        check("wb_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
    if (dmem.dmem_req === 1'b1) begin
      req_seen++;
      rq_cnt++;
      check("dmem_addr", dmem.dmem_addr, exp_addr);
      check("dmem_we", 64'(dmem.dmem_we), 64'(exp_we));
      check("dmem_wdata", dmem.dmem_wdata, exp_wdata);
      check("ready_in_req", 64'(ex_ready), 64'd0);
    end else begin
      rq_cnt = 0;
    end
    dmem.dmem_ack   = force_ack || (dmem.dmem_req === 1'b1 && ack_delay > 0 && rq_cnt == ack_delay);
    dmem.dmem_rdata = dmem.dmem_ack ? ack_data : 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input stim_t s);
    ALU_result   = s.alu;
    ADD_result   = s.add;
    rd_data_2    = s.wd;
    Zero         = s.zero;
    MemRead      = s.mr;
    MemWrite     = s.mw;
    Branch       = s.br;
    UncondBranch = s.ub;
    MemtoReg     = s.m2r;
    RegWrite     = s.rw;
    rd_in        = s.rd;
  endtask

  task automatic issue(input stim_t s, input bit wait_done);
    exp_t e;
    bit   mem_op, mis, access, taken;
    int   base, g;
    g = 0;
    while (ex_ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    if (ex_ready !== 1'b1) check("ready_wait", 64'(ex_ready), 64'd1);
    mem_op    = s.mr | s.mw;
    mis       = (s.alu[2:0] != 3'b000);
    access    = mem_op && !mis;
    taken     = s.ub | (s.br & s.zero);
    ack_delay = s.delay;
    ack_data  = s.rdata;
    exp_addr  = s.alu;
    exp_wdata = s.wd;
    exp_we    = s.mw;
    e.fault   = mem_op && (mis || s.delay == 0);
    e.alu     = s.alu;
    e.rd      = s.rd;
    e.m2r     = s.m2r;
    e.rw      = s.rw && !e.fault;
    e.rdata   = (access && !s.mw && s.delay > 0) ? s.rdata : 64'd0;
    e.acc     = cyc;
    e.lat     = !access ? 1 : (s.delay > 0 ? s.delay + 1 : TIMEOUT + 1);
    sb.push_back(e);
    base = req_seen;
    drive(s);
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("PCSrc", 64'(PCSrc), 64'(taken));
    if (taken) check("branch_target", branch_target, s.add);
    check("req_issue", 64'(dmem.dmem_req), 64'(access));
    check("ready_after_accept", 64'(ex_ready), 64'(!access));
    if (wait_done) begin
      tick();
      check("PCSrc_pulse_end", 64'(PCSrc), 64'd0);
      g = 0;
      while (sb.size() != 0 && g < 200) begin
        tick();
        g++;
      end
      if (sb.size() != 0) begin
        check("wb_wait", 64'(sb.size()), 64'd0);
        sb.delete();
      end
      check("req_cycles", 64'(req_seen - base),
            64'(access ? (s.delay > 0 ? s.delay : TIMEOUT) : 0));
    end
  endtask

  initial begin
    stim_t s;
    reset    = 1'b1;
    ex_valid = 1'b0;
    drive('{default: '0});
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    repeat (3) tick();

    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_PCSrc", 64'(PCSrc), 64'd0);
    check("rst_branch_target", branch_target, 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_RegWrite", 64'(wb_RegWrite), 64'd0);
    check("rst_wb_MemtoReg", 64'(wb_MemtoReg), 64'd0);
    check("rst_wb_read_data", wb_read_data, 64'd0);
    check("rst_wb_ALU_result", wb_ALU_result, 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_mem_fault", 64'(mem_fault), 64'd0);
    check("rst_dmem_req", 64'(dmem.dmem_req), 64'd0);
    check("rst_dmem_we", 64'(dmem.dmem_we), 64'd0);
    check("rst_dmem_addr", dmem.dmem_addr, 64'd0);
    check("rst_dmem_wdata", dmem.dmem_wdata, 64'd0);
    reset = 1'b0;
    tick();

    // ADD, LDUR with 3-cycle ack, STUR acked in first REQ cycle
    issue('{alu: 64'h2A, rw: 1'b1, rd: 5'd5, default: '0}, 1'b1);
    issue('{alu: 64'h100, mr: 1'b1, m2r: 1'b1, rw: 1'b1, rd: 5'd9,
            rdata: 64'hDEADBEEF, delay: 3, default: '0}, 1'b1);
    issue('{alu: 64'h108, wd: 64'h55, mw: 1'b1, rd: 5'd3, delay: 1,
            rdata: 64'h1234, default: '0}, 1'b1);
    // CBZ taken / not taken, B with Zero=0
    issue('{add: 64'h400, zero: 1'b1, br: 1'b1, alu: 64'h0, default: '0}, 1'b1);
    issue('{add: 64'h400, zero: 1'b0, br: 1'b1, alu: 64'h7, default: '0}, 1'b1);
    issue('{add: 64'h800, zero: 1'b0, ub: 1'b1, alu: 64'h1, default: '0}, 1'b1);
    // misaligned load and store fault without an access
    issue('{alu: 64'h103, mr: 1'b1, m2r: 1'b1, rw: 1'b1, rd: 5'd4,
            delay: 1, rdata: 64'hFFFF, default: '0}, 1'b1);
    issue('{alu: 64'h10C, wd: 64'h77, mw: 1'b1, rw: 1'b1, rd: 5'd6,
            delay: 1, default: '0}, 1'b1);
    // load never acked: timeout fault
    issue('{alu: 64'h200, mr: 1'b1, m2r: 1'b1, rw: 1'b1, rd: 5'd7,
            delay: 0, rdata: 64'hCAFE, default: '0}, 1'b1);
    // MemRead and MemWrite together behave as a store
    issue('{alu: 64'h110, wd: 64'hABCD, mr: 1'b1, mw: 1'b1, rd: 5'd8,
            delay: 2, rdata: 64'h9999, default: '0}, 1'b1);
    // back-to-back accept in the WB cycle
    issue('{alu: 64'h11, rw: 1'b1, rd: 5'd1, default: '0}, 1'b0);
    issue('{alu: 64'h22, rw: 1'b1, rd: 5'd2, default: '0}, 1'b1);

    for (int i = 0; i < 6; i++) begin
      s = '{default: '0};
      s.rd = 5'($urandom_range(0, 31));
      s.rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: s.alu = {$urandom, $urandom};
        1: begin
          s.alu = {$urandom, $urandom} & ~64'h7;
          s.mr = 1'b1; s.m2r = 1'b1;
          s.delay = int'($urandom_range(1, 4));
          s.rdata = {$urandom, $urandom};
        end
        default: begin
          s.alu = {$urandom, $urandom} & ~64'h7;
          s.mw = 1'b1;
          s.wd = {$urandom, $urandom};
          s.delay = int'($urandom_range(1, 4));
        end
      endcase
      issue(s, 1'b1);
    end

    // reset while a request is outstanding, then a late ack
    exp_addr  = 64'h300;
    exp_wdata = 64'h0;
    exp_we    = 1'b0;
    ack_delay = 0;
    drive('{alu: 64'h300, mr: 1'b1, m2r: 1'b1, rw: 1'b1, rd: 5'd10, default: '0});
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("rstreq_req_before", 64'(dmem.dmem_req), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rstreq_req_after", 64'(dmem.dmem_req), 64'd0);
    check("rstreq_wb_valid", 64'(wb_valid), 64'd0);
    check("rstreq_ex_ready", 64'(ex_ready), 64'd1);
    reset     = 1'b0;
    force_ack = 1'b1;
    ack_data  = 64'h5A5A;
    repeat (4) begin
      tick();
      check("late_ack_wb", 64'(wb_valid), 64'd0);
    end
    force_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- LEGv8 memory stage: the consumer of execute-stage results (ALU_result, ADD_result, Zero, rd_data_2, control bits).
- Registers one execute bundle, resolves the branch (PCSrc and target), and runs a data-memory access over a req/ack handshake with timeout.
- Presents a one-cycle write-back bundle to WB.
- Stalls execute via ex_ready while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath and address width.
- TIMEOUT, 16, cycles to wait for dmem_ack before aborting with a fault; range 1..255.
- CHECK_ALIGN, 1, when 1 a load/store with addr[2:0]!=0 faults without a memory access.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  execute bundle valid.
- ex_ready  out  1  stage can accept a bundle this cycle.
- ALU_result  in  XLEN  memory address, or pass-through result.
- ADD_result  in  XLEN  branch target.
- Zero  in  1  ALU zero flag.
- rd_data_2  in  XLEN  store data.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- Branch  in  1  conditional branch (CBZ).
- UncondBranch  in  1  unconditional branch (B).
- MemtoReg  in  1  WB selects load data.
- RegWrite  in  1  WB writes the register file.
- rd_in  in  5  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  address.
- dmem_wdata  out  XLEN  write data.
- dmem_rdata  in  XLEN  read data, valid with dmem_ack.
- dmem_ack  in  1  request complete.
- PCSrc  out  1  take branch; one-cycle pulse.
- branch_target  out  XLEN  valid when PCSrc=1.
- wb_valid  out  1  write-back bundle valid; one-cycle pulse.
- wb_RegWrite  out  1  RegWrite for WB.
- wb_MemtoReg  out  1  MemtoReg for WB.
- wb_read_data  out  XLEN  load data.
- wb_ALU_result  out  XLEN  registered ALU_result.
- wb_rd  out  5  destination register.
- mem_fault  out  1  misalignment or timeout; valid with wb_valid.

Behaviour:
- Reset value of every output is 0, with one exception: ex_ready=1. State resets to IDLE and the timeout counter to 0.
- States and transitions:
  - IDLE: ex_ready=1.
    - On ex_valid, capture the bundle.
    - If (MemRead|MemWrite) and not misaligned, go to REQ.
    - Otherwise go to WB; a misaligned memory op takes this path with fault set.
  - REQ: ex_ready=0. dmem_req=1 and dmem_we=captured MemWrite; dmem_addr and dmem_wdata come from the captured registers and are held stable while req=1.
    - On dmem_ack: latch dmem_rdata into wb_read_data if the op is a load, drop req, go to WB.
    - If no ack by the time the counter reaches TIMEOUT: drop req, set fault, go to WB.
  - WB: wb_valid=1 for exactly one cycle. ex_ready=1, so a back-to-back accept in this cycle moves the FSM as from IDLE; otherwise return to IDLE.
- Latency:
  - Non-memory op: wb_valid one cycle after acceptance.
  - Memory op with ack in its first REQ cycle: wb_valid two cycles after acceptance.
- Branch resolution:
  - PCSrc = UncondBranch | (Branch & Zero), evaluated on the accepted bundle.
  - Registered; pulses in the cycle after acceptance together with branch_target=ADD_result.
  - Independent of memory timing.
- Fault path:
  - A faulting op forces wb_RegWrite=0.
  - A faulting load returns wb_read_data=0.
  - A faulting store performs no write.
- Write-back fields:
  - wb_ALU_result, wb_rd and wb_MemtoReg come from the captured bundle.
  - For a store, wb_RegWrite equals the captured RegWrite; control normally makes it 0.
- Handshake: if MemRead and MemWrite are both set, the op is treated as a store.
- dmem_ack outside REQ is ignored.
- Timeout counter: 8-bit; clears on entry to REQ; saturates, no wrap.
- Reset in REQ: dmem_req is low after that edge, and a late ack arriving after reset is ignored.
- Reset in WB: the pending wb_valid is suppressed.

Decomposition:
- Shared package legv8_pkg holds:
  - XLEN;
  - the state enum (IDLE, REQ, WB);
  - an ex_mem bundle struct (result, target, zero, store data, control bits, rd).
- One sub-module, mem_timeout_counter: clear, enable, terminal-count flag at TIMEOUT.

Test Plan:
- Reset with ex_valid=0 -> all outputs 0, ex_ready=1. Assert reset during REQ -> dmem_req=0 next cycle; a subsequent ack produces no wb_valid.
- ADD bundle (ALU_result=0x2A, RegWrite=1, rd=5) -> wb_valid one cycle later with wb_ALU_result=0x2A, wb_rd=5, wb_RegWrite=1, no dmem_req.
- LDUR address 0x100, ack with rdata=0xDEADBEEF after 3 cycles -> dmem_req high exactly 3 cycles with addr 0x100; ex_ready=0 during them; wb_read_data=0xDEADBEEF, wb_MemtoReg=1.
- STUR address 0x108, wdata=0x55, ack on the first REQ cycle -> dmem_we=1, wdata=0x55; wb_valid two cycles after accept; mem_fault=0.
- CBZ with Zero=1, ADD_result=0x400 -> PCSrc=1, branch_target=0x400 for one cycle. Same with Zero=0 -> PCSrc stays 0. B with Zero=0 -> PCSrc=1.
- LDUR address 0x103 (CHECK_ALIGN=1) -> no dmem_req; wb_valid next cycle with mem_fault=1, wb_RegWrite=0. LDUR with no ack -> req held TIMEOUT cycles, then mem_fault=1 and wb_read_data=0.
